bcd_stopwatch: RTL and testbench
================================

# bcd_stopwatch

Decimal stopwatch counter driven by the one-cycle enable pulse from the frequency divider (`frq_div`). Each `tick` advances a multi-digit BCD count while the block is running. The block takes start/stop, clear and lap commands and presents a display value (live or lap-frozen) to the downstream seven-segment/display stage. Everything runs on the master clock; `tick` is a clock enable, never a clock.

## Interface

Parameters
- `DIGITS`, default 4: number of BCD digits; count width is 4*DIGITS.

Ports
- `mclk`  in  1  master clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tick`  in  1  one-`mclk`-wide enable pulse from the divider; one count step per pulse.
- `start_stop`  in  1  one-cycle command pulse: toggles run/pause.
- `clear`  in  1  one-cycle command pulse: zero the stopwatch and return to IDLE.
- `lap`  in  1  one-cycle command pulse: freeze or release the display.
- `count`  out  4*DIGITS  live BCD count; digit 0 is in bits [3:0].
- `disp`  out  4*DIGITS  display value: the lap register when the lap hold is active, otherwise `count`.
- `running`  out  1  high in the RUN state.
- `lap_hold`  out  1  high while the display is frozen.
- `ovf`  out  1  sticky overflow flag.
- `wrap`  out  1  one-cycle pulse on the edge the count wraps from all-9s to 0.

## Operation

- **States:** IDLE (reset state), RUN, PAUSE. Encoding is free; `running` = (state==RUN).
- **Transitions on `start_stop`:** IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
- **`clear`:** any state -> IDLE. Sets `count`=0, lap register=0, `lap_hold`=0, `ovf`=0.
- **Command priority per edge:** `rst` > `clear` > `start_stop`/`lap`. `start_stop` and `lap` in the same cycle are both honoured.
- **Counting:** `count` increments by one on any edge where the registered state is RUN and `tick`=1. The registered state is the state before this edge's transition, so:
  - IDLE->RUN with a coincident `tick`: no increment.
  - RUN->PAUSE with a coincident `tick`: increments.
- **BCD arithmetic:** digit 0 adds 1. A digit at 9 that receives a carry becomes 0 and carries to the next digit. Digits never hold values 10–15.
- **Wrap:** incrementing from all-9s gives all-0s. On that edge `wrap`=1 for exactly one cycle and `ovf` sets; `ovf` stays high until `clear` or `rst`.
- **Lap:**
  - `lap` with `lap_hold`=0 in RUN: lap register <= current `count` (the value before any coincident increment), and `lap_hold` <= 1.
  - `lap` with `lap_hold`=0 in IDLE or PAUSE: ignored.
  - `lap` with `lap_hold`=1 in any state: `lap_hold` <= 0.
  - `count` keeps advancing during a hold.
- **`tick` outside RUN:** no effect.
- **`tick` wider than one cycle:** the block counts once per high cycle; the divider guarantees one-cycle pulses.

## Timing

- **Reset:** `rst` sampled high sets state=IDLE and clears `count`, `disp`, the lap register, `running`, `lap_hold`, `ovf` and `wrap` to 0 at that edge. Reset applied mid-count or mid-hold behaves identically.
- **Registered outputs:** all outputs except `disp` are registered and reflect the edge at which the input was sampled.
- **`disp`:** a combinational mux of registers, so it is valid in the same cycle as `count` and `lap_hold`.
- **Command latency:** one edge from a command pulse to the visible state/flag change.
- **Increment latency:** `count` changes at the edge sampling `tick`=1, with no further pipeline.
- **`wrap`:** aligned with the edge where `count` becomes 0; it is low on every other cycle.
- **Carry resolution:** the full carry chain resolves within one `mclk` cycle for all `DIGITS`.

## Test plan

1. **Reset:** hold `rst`=1 for 2 cycles during RUN with a count of 0x0123 -> all outputs 0, state IDLE; `tick` pulses afterwards leave `count`=0.
2. **Basic counting:** pulse `start_stop`, then 10 ticks (`tick` every 10 cycles) -> `count`=0x0010 and `running`=1. The carry 0x0009->0x0010 happens on a single edge.
3. **Full wrap:** run 10000 ticks -> `count` goes 0x9999 -> 0x0000, `wrap` is high for one cycle, and `ovf` stays 1. After `clear`, `ovf`=0.
4. **Pause boundary:** with `count`=0x0005, assert `start_stop` and `tick` in the same cycle -> `count`=0x0006, `running`=0. Later ticks leave it at 0x0006; `start_stop` resumes counting.
5. **Lap:** at `count`=0x0042 pulse `lap` -> `disp`=0x0042 and `lap_hold`=1 while `count` reaches 0x0050. A second `lap` -> `disp`=0x0050, `lap_hold`=0. `lap` in PAUSE with `lap_hold`=0 -> no change.
6. **Priority:** in RUN at 0x0777, assert `clear`, `start_stop`, `lap` and `tick` together -> IDLE, `count`=0, `disp`=0, `lap_hold`=0, `running`=0.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: run/pause/clear BCD stopwatch with lap-freeze display and wrap/overflow flags
module bcd_stopwatch #(
    parameter int DIGITS = 4
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  running,
    output logic                  lap_hold,
    output logic                  ovf,
    output logic                  wrap
);
    localparam int W = 4 * DIGITS;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t         r_state, w_next;
    logic [W-1:0]   r_count, r_lap, w_inc_val;
    logic           r_hold, r_ovf, r_wrap;
    logic [DIGITS:0] w_c;
    logic           w_inc, w_wrap, w_take, w_release;
    always_ff @(posedge mclk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = clear ? IDLE : !start_stop ? r_state : (r_state == RUN ? PAUSE : RUN);
    end
    always_comb begin
        w_inc     = (r_state == RUN) & tick;
        w_wrap    = w_inc & w_c[DIGITS];
        w_take    = lap & !r_hold & (r_state == RUN);
        w_release = lap & r_hold;
    end
    assign w_c[0] = 1'b1;
    genvar d;
    for (d = 0; d < DIGITS; d++) begin : g_dig
        logic [3:0] w_dig;
        assign w_dig = r_count[4*d +: 4];
        assign w_inc_val[4*d +: 4] = w_c[d] ? (w_dig == 4'd9 ? 4'd0 : w_dig + 4'd1) : w_dig;
        assign w_c[d+1] = w_c[d] & (w_dig == 4'd9);
    end
    always_ff @(posedge mclk) begin
        if (rst || clear) begin
            r_count <= '0;
            r_lap   <= '0;
            r_hold  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            if (w_inc) r_count <= w_inc_val;
            if (w_take) r_lap <= r_count;
            r_hold <= w_take ? 1'b1 : w_release ? 1'b0 : r_hold;
            r_ovf  <= r_ovf | w_wrap;
            r_wrap <= w_wrap;
        end
    end
    assign count    = r_count;
    assign disp     = r_hold ? r_lap : r_count;
    assign running  = (r_state == RUN);
    assign lap_hold = r_hold;
    assign ovf      = r_ovf;
    assign wrap     = r_wrap;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed stimulus with queued expectations checked by a separate monitor
module tb_bcd_stopwatch;
    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] count, disp;
    logic        running, lap_hold, ovf, wrap;

    typedef struct {
        string       name;
        logic [15:0] c;
        logic [15:0] d;
        logic        r;
        logic        h;
        logic        o;
        logic        w;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;

    bcd_stopwatch #(.DIGITS(4)) dut (
        .mclk(mclk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .count(count), .disp(disp),
        .running(running), .lap_hold(lap_hold), .ovf(ovf), .wrap(wrap)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({count, disp, running, lap_hold, ovf, wrap} !== {e.c, e.d, e.r, e.h, e.o, e.w}) begin
                failures++;
                $display("FAIL %s: got count=%h disp=%h run=%b hold=%b ovf=%b wrap=%b, expected count=%h disp=%h run=%b hold=%b ovf=%b wrap=%b",
                         e.name, count, disp, running, lap_hold, ovf, wrap, e.c, e.d, e.r, e.h, e.o, e.w);
            end
        end
    end

    task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
        tick = t; start_stop = ss; clear = cl; lap = lp;
        @(posedge mclk);
        #1;
        tick = 0; start_stop = 0; clear = 0; lap = 0;
    endtask

    task automatic tickn(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0);
            for (int j = 1; j < gap; j++) step(0, 0, 0, 0);
        end
    endtask

    task automatic expect_out(input string name, input logic [15:0] c, input logic [15:0] d,
                              input logic r, input logic h, input logic o, input logic w);
        exp_t e;
        e.name = name; e.c = c; e.d = d; e.r = r; e.h = h; e.o = o; e.w = w;
        q.push_back(e);
    endtask

    initial begin
        // reset
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        expect_out("reset_initial", 16'h0000, 16'h0000, 0, 0, 0, 0);
        rst = 0;
        step(0, 1, 0, 0);
        tickn(123, 1);
        expect_out("pre_reset_run", 16'h0123, 16'h0123, 1, 0, 0, 0);
        rst = 1;
        step(0, 0, 0, 0);
        expect_out("reset_mid_run_1", 16'h0000, 16'h0000, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("reset_mid_run_2", 16'h0000, 16'h0000, 0, 0, 0, 0);
        rst = 0;
        tickn(3, 2);
        expect_out("ticks_in_idle", 16'h0000, 16'h0000, 0, 0, 0, 0);
        // basic counting
        step(0, 1, 0, 0);
        expect_out("start", 16'h0000, 16'h0000, 1, 0, 0, 0);
        tickn(9, 10);
        expect_out("count_9", 16'h0009, 16'h0009, 1, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("carry_to_10", 16'h0010, 16'h0010, 1, 0, 0, 0);
        // full wrap
        tickn(9989, 1);
        expect_out("at_9999", 16'h9999, 16'h9999, 1, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("wrap_edge", 16'h0000, 16'h0000, 1, 0, 1, 1);
        step(0, 0, 0, 0);
        expect_out("wrap_one_cycle", 16'h0000, 16'h0000, 1, 0, 1, 0);
        step(1, 0, 0, 0);
        expect_out("ovf_sticky", 16'h0001, 16'h0001, 1, 0, 1, 0);
        step(0, 0, 1, 0);
        expect_out("clear_ovf", 16'h0000, 16'h0000, 0, 0, 0, 0);
        // pause boundary
        step(1, 1, 0, 0);
        expect_out("start_with_tick", 16'h0000, 16'h0000, 1, 0, 0, 0);
        tickn(5, 1);
        expect_out("count_5", 16'h0005, 16'h0005, 1, 0, 0, 0);
        step(1, 1, 0, 0);
        expect_out("pause_with_tick", 16'h0006, 16'h0006, 0, 0, 0, 0);
        tickn(3, 1);
        expect_out("paused_ticks", 16'h0006, 16'h0006, 0, 0, 0, 0);
        step(0, 1, 0, 0);
        expect_out("resume", 16'h0006, 16'h0006, 1, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("resume_count", 16'h0007, 16'h0007, 1, 0, 0, 0);
        // lap
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        tickn(42, 1);
        expect_out("count_42", 16'h0042, 16'h0042, 1, 0, 0, 0);
        step(0, 0, 0, 1);
        expect_out("lap_take", 16'h0042, 16'h0042, 1, 1, 0, 0);
        tickn(8, 1);
        expect_out("lap_frozen", 16'h0050, 16'h0042, 1, 1, 0, 0);
        step(0, 0, 0, 1);
        expect_out("lap_release", 16'h0050, 16'h0050, 1, 0, 0, 0);
        step(1, 0, 0, 1);
        expect_out("lap_with_tick", 16'h0051, 16'h0050, 1, 1, 0, 0);
        step(0, 0, 0, 1);
        expect_out("lap_release_2", 16'h0051, 16'h0051, 1, 0, 0, 0);
        step(0, 1, 0, 0);
        expect_out("pause_for_lap", 16'h0051, 16'h0051, 0, 0, 0, 0);
        step(0, 0, 0, 1);
        expect_out("lap_in_pause", 16'h0051, 16'h0051, 0, 0, 0, 0);
        step(0, 1, 0, 1);
        expect_out("lap_with_resume", 16'h0051, 16'h0051, 1, 0, 0, 0);
        // priority
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        tickn(777, 1);
        expect_out("count_777", 16'h0777, 16'h0777, 1, 0, 0, 0);
        step(1, 1, 1, 1);
        expect_out("clear_priority", 16'h0000, 16'h0000, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("idle_after_clear", 16'h0000, 16'h0000, 0, 0, 0, 0);
        @(negedge mclk); #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
